contador_programa: RTL and testbench
====================================

# contador_programa

Program-counter stage of the processor. Registers the next-instruction address produced by the branch stage and drives `PCAtual` back to it and to instruction memory. Holds the PC during halt and input-wait states. Keeps a small hardware return-address stack for call/return instructions.

## Interface
Parameters:
- `PROFUNDIDADE_PILHA`, default 8: number of return-address stack entries (power of two, ≥2).
- `LARGURA_PC`, default 10: PC width in bits.

Ports:
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `NovoEndereco`  in  LARGURA_PC  next address from the branch stage (branch target or PC+1).
- `Chamada`  in  1  current instruction is a call: push return address, jump to `NovoEndereco`.
- `Retorno`  in  1  current instruction is a return: pop stack into PC.
- `Halt`  in  1  current instruction is halt.
- `EsperaEntrada`  in  1  current instruction reads user input; stall until `EntradaPronta`.
- `EntradaPronta`  in  1  single-cycle pulse: user input is valid.
- `PCAtual`  out  LARGURA_PC  registered current PC.
- `Parado`  out  1  block is in the PARADO state.
- `Esperando`  out  1  block is in the ESPERA state.
- `ErroPilha`  out  1  sticky flag: stack overflow or underflow.
- `NivelPilha`  out  clog2(PROFUNDIDADE_PILHA)+1  current number of stack entries.

## Operation
- There are three states: EXECUTA, ESPERA, PARADO.
- Reset forces EXECUTA, `PCAtual`=0, stack empty (`NivelPilha`=0), `Parado`=0, `Esperando`=0, `ErroPilha`=0. Reset takes precedence in every state, including mid-wait and after an error.
- EXECUTA: exactly one action per edge, chosen by this priority:
  - `Halt`: PC holds; go to PARADO.
  - `Retorno`: if the stack is non-empty, PC ← top entry and the stack pops. If it is empty (underflow), `ErroPilha` ← 1, PC holds, go to PARADO.
  - `Chamada`: if the stack is not full, push (`PCAtual`+1) mod 2^LARGURA_PC and PC ← `NovoEndereco`. If it is full (overflow), `ErroPilha` ← 1, PC holds, stack unchanged, go to PARADO.
  - `EsperaEntrada`: PC holds; go to ESPERA.
  - Otherwise: PC ← `NovoEndereco`.
- When `Retorno` and `Chamada` are asserted together, `Retorno` wins and `Chamada` is ignored.
- ESPERA:
  - PC holds while `EntradaPronta`=0.
  - When `EntradaPronta`=1, PC ← `NovoEndereco` and the state returns to EXECUTA.
  - `Halt`, `Chamada` and `Retorno` are ignored.
- PARADO: PC, stack and flags are frozen. Only `reset` exits this state.
- The stack is LIFO with a write pointer. A push writes entry[`NivelPilha`] and increments. A pop reads entry[`NivelPilha`-1] and decrements. Entries are not cleared by reset, but they are unobservable while empty.
- The return address wraps: a call at PC 1023 (LARGURA_PC=10) pushes 0.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- `PCAtual` changes one edge after the qualifying control inputs are sampled. The branch stage's combinational PC+1 therefore sees the new PC in the same cycle.
- `Parado` and `Esperando` assert on the same edge that enters their state. `Esperando` deasserts on the edge that consumes `EntradaPronta`.
- An `EntradaPronta` pulse arriving in EXECUTA (before ESPERA is entered) is ignored. It is not latched.
- `NivelPilha` updates on the push/pop edge. A call followed directly by a return in the next cycle returns to the pushed address (no bypass hazard).

## Test plan
- Reset, then `NovoEndereco` sequenced 1,2,3 with no controls → `PCAtual` 0,1,2,3 on successive edges; `Parado`=`Esperando`=0.
- At PC=5, `Chamada` with `NovoEndereco`=40 → PC=40, `NivelPilha`=1. Next cycle `Retorno` → PC=6, `NivelPilha`=0.
- Nine consecutive calls with depth 8 → first eight push; ninth sets `ErroPilha`=1 and `Parado`=1 with PC unchanged. Assert `reset` → all outputs return to reset values.
- `Retorno` on an empty stack → `ErroPilha`=1, `Parado`=1; subsequent `NovoEndereco` changes do not move PC.
- At PC=12, `EsperaEntrada` → `Esperando`=1, PC stays 12 for 5 cycles. `EntradaPronta` pulse with `NovoEndereco`=13 → PC=13, `Esperando`=0. `Halt` while waiting is ignored.
- Call at PC=1023 with target 100, then return → PC=0. `Halt`+`Retorno` together → PARADO, stack level unchanged.

Source files
------------

// File: rtl/contador_programa.sv
// Program-counter stage: registers the next instruction address, stalls on halt
// and input wait, and keeps a hardware return-address stack for call/return.
module contador_programa #(
    parameter int unsigned PROFUNDIDADE_PILHA = 8,
    parameter int unsigned LARGURA_PC         = 10
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [LARGURA_PC-1:0]                 NovoEndereco,
    input  logic                                  Chamada,
    input  logic                                  Retorno,
    input  logic                                  Halt,
    input  logic                                  EsperaEntrada,
    input  logic                                  EntradaPronta,
    output logic [LARGURA_PC-1:0]                 PCAtual,
    output logic                                  Parado,
    output logic                                  Esperando,
    output logic                                  ErroPilha,
    output logic [$clog2(PROFUNDIDADE_PILHA):0]   NivelPilha
);

    localparam int unsigned IW = $clog2(PROFUNDIDADE_PILHA);
    localparam int unsigned NW = IW + 1;

    typedef enum logic [1:0] {
        EXECUTA = 2'd0,
        ESPERA  = 2'd1,
        PARADO  = 2'd2
    } estado_t;

    estado_t                estado_q, estado_d;
    logic [LARGURA_PC-1:0]  pc_q, pc_d;
    logic [NW-1:0]          nivel_q, nivel_d;
    logic                   erro_q, erro_d;
    logic                   parado_q, parado_d;
    logic                   esperando_q, esperando_d;
    logic [LARGURA_PC-1:0]  pilha_q [PROFUNDIDADE_PILHA];

    logic                   push_s;
    logic                   vazia_s;
    logic                   cheia_s;
    logic [IW-1:0]          idx_push_s;
    logic [IW-1:0]          idx_topo_s;
    logic [LARGURA_PC-1:0]  retorno_s;

    assign vazia_s    = (nivel_q == {NW{1'b0}});
    assign cheia_s    = (nivel_q == NW'(PROFUNDIDADE_PILHA));
    assign idx_push_s = nivel_q[IW-1:0];
    assign idx_topo_s = nivel_q[IW-1:0] - IW'(1);
    // Return address wraps naturally at the PC width.
    assign retorno_s  = pc_q + LARGURA_PC'(1);

    // Next-state, next-PC and stack-pointer decision for the current instruction.
    always_comb begin
        estado_d = estado_q;
        pc_d     = pc_q;
        nivel_d  = nivel_q;
        erro_d   = erro_q;
        push_s   = 1'b0;
        case (estado_q)
            EXECUTA: begin
                if (Halt) begin
                    estado_d = PARADO;
                end else if (Retorno) begin
                    if (!vazia_s) begin
                        pc_d    = pilha_q[idx_topo_s];
                        nivel_d = nivel_q - NW'(1);
                    end else begin
                        erro_d   = 1'b1;
                        estado_d = PARADO;
                    end
                end else if (Chamada) begin
                    if (!cheia_s) begin
                        push_s  = 1'b1;
                        nivel_d = nivel_q + NW'(1);
                        pc_d    = NovoEndereco;
                    end else begin
                        erro_d   = 1'b1;
                        estado_d = PARADO;
                    end
                end else if (EsperaEntrada) begin
                    estado_d = ESPERA;
                end else begin
                    pc_d = NovoEndereco;
                end
            end
            ESPERA: begin
                if (EntradaPronta) begin
                    pc_d     = NovoEndereco;
                    estado_d = EXECUTA;
                end else begin
                    pc_d = pc_q;
                end
            end
            PARADO: begin
                estado_d = PARADO;
            end
            // Unreachable encoding: freeze rather than run from a corrupt state.
            default: begin
                estado_d = PARADO;
            end
        endcase
        parado_d    = (estado_d == PARADO);
        esperando_d = (estado_d == ESPERA);
    end

    // State, PC, flags and stack registers; stack entries are never cleared.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= EXECUTA;
            pc_q        <= {LARGURA_PC{1'b0}};
            nivel_q     <= {NW{1'b0}};
            erro_q      <= 1'b0;
            parado_q    <= 1'b0;
            esperando_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            pc_q        <= pc_d;
            nivel_q     <= nivel_d;
            erro_q      <= erro_d;
            parado_q    <= parado_d;
            esperando_q <= esperando_d;
            if (push_s) begin
                pilha_q[idx_push_s] <= retorno_s;
            end
        end
    end

    assign PCAtual    = pc_q;
    assign Parado     = parado_q;
    assign Esperando  = esperando_q;
    assign ErroPilha  = erro_q;
    assign NivelPilha = nivel_q;

endmodule

// File: tb/tb_contador_programa.sv
// Self-checking bench for contador_programa: directed scenarios plus random
// stimulus compared against a queue-based behavioural model.
module tb_contador_programa;

    localparam int W = 10;
    localparam int D = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic [W-1:0] NovoEndereco;
    logic         Chamada, Retorno, Halt, EsperaEntrada, EntradaPronta;
    logic [W-1:0] PCAtual;
    logic         Parado, Esperando, ErroPilha;
    logic [3:0]   NivelPilha;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 = running, 1 = waiting for input, 2 = halted.
    logic [W-1:0] m_pc;
    logic [W-1:0] m_pilha[$];
    logic         m_erro;
    int           m_modo;

    contador_programa #(.PROFUNDIDADE_PILHA(D), .LARGURA_PC(W)) dut (
        .clock(clock), .reset(reset), .NovoEndereco(NovoEndereco),
        .Chamada(Chamada), .Retorno(Retorno), .Halt(Halt),
        .EsperaEntrada(EsperaEntrada), .EntradaPronta(EntradaPronta),
        .PCAtual(PCAtual), .Parado(Parado), .Esperando(Esperando),
        .ErroPilha(ErroPilha), .NivelPilha(NivelPilha)
    );

    always #5 clock = ~clock;

    task automatic step(input logic rst, input logic [W-1:0] novo, input logic ch,
                        input logic re, input logic ha, input logic es, input logic pr);
        reset = rst; NovoEndereco = novo; Chamada = ch; Retorno = re;
        Halt = ha; EsperaEntrada = es; EntradaPronta = pr;
        @(posedge clock);
        #1;
        if (rst) begin
            m_pc = '0; m_pilha.delete(); m_erro = 1'b0; m_modo = 0;
        end else if (m_modo == 0) begin
            if (ha) m_modo = 2;
            else if (re) begin
                if (m_pilha.size() > 0) m_pc = m_pilha.pop_back();
                else begin m_erro = 1'b1; m_modo = 2; end
            end else if (ch) begin
                if (m_pilha.size() < D) begin
                    m_pilha.push_back(W'((int'(m_pc) + 1) % (1 << W)));
                    m_pc = novo;
                end else begin m_erro = 1'b1; m_modo = 2; end
            end else if (es) m_modo = 1;
            else m_pc = novo;
        end else if (m_modo == 1) begin
            if (pr) begin m_pc = novo; m_modo = 0; end
        end
    endtask

    task automatic test_reset();
        step(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (PCAtual !== 10'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", PCAtual); end
        checks++; if ({Parado, Esperando, ErroPilha} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {Parado, Esperando, ErroPilha}); end
        checks++; if (NivelPilha !== 4'd0) begin errors++; $display("FAIL reset_nivel: got %0d expected 0", NivelPilha); end
    endtask

    task automatic test_sequencial();
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, W'(i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++; if (PCAtual !== W'(i)) begin errors++; $display("FAIL seq_pc: got %0d expected %0d", PCAtual, i); end
            checks++; if ({Parado, Esperando} !== 2'b00) begin errors++; $display("FAIL seq_flags: got %b expected 00", {Parado, Esperando}); end
        end
    endtask

    task automatic test_chamada_retorno();
        step(1'b0, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'd40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (PCAtual !== 10'd40 || NivelPilha !== 4'd1) begin errors++; $display("FAIL call_pc_nivel: got %0d/%0d expected 40/1", PCAtual, NivelPilha); end
        step(1'b0, 10'd77, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (PCAtual !== 10'd6 || NivelPilha !== 4'd0) begin errors++; $display("FAIL ret_pc_nivel: got %0d/%0d expected 6/0", PCAtual, NivelPilha); end
    endtask

    task automatic test_overflow();
        step(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, W'(10 + i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (NivelPilha !== 4'd8 || PCAtual !== 10'd17) begin errors++; $display("FAIL ovf_full: got %0d/%0d expected 8/17", NivelPilha, PCAtual); end
        step(1'b0, 10'd300, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if ({ErroPilha, Parado} !== 2'b11 || PCAtual !== 10'd17 || NivelPilha !== 4'd8) begin
            errors++; $display("FAIL ovf_err: got err/par=%b pc=%0d nivel=%0d expected 11 17 8", {ErroPilha, Parado}, PCAtual, NivelPilha); end
        step(1'b1, 10'd300, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if ({PCAtual, Parado, Esperando, ErroPilha, NivelPilha} !== 17'd0) begin
            errors++; $display("FAIL ovf_reset: got pc=%0d flags=%b nivel=%0d expected all 0", PCAtual, {Parado, Esperando, ErroPilha}, NivelPilha); end
    endtask

    task automatic test_underflow();
        step(1'b0, 10'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if ({ErroPilha, Parado} !== 2'b11) begin errors++; $display("FAIL unf_err: got %b expected 11", {ErroPilha, Parado}); end
        step(1'b0, 10'd99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'd98, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (PCAtual !== 10'd0 || Parado !== 1'b1) begin errors++; $display("FAIL unf_frozen: got pc=%0d par=%b expected 0 1", PCAtual, Parado); end
    endtask

    task automatic test_espera();
        step(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'd13, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (Esperando !== 1'b1 || PCAtual !== 10'd12) begin errors++; $display("FAIL esp_enter: got esp=%b pc=%0d expected 1 12", Esperando, PCAtual); end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, W'($urandom), i == 1, i == 3, i == 2, 1'b0, 1'b0);
            checks++; if (PCAtual !== 10'd12 || {Esperando, Parado} !== 2'b10 || NivelPilha !== 4'd0) begin
                errors++; $display("FAIL esp_hold: got pc=%0d esp/par=%b nivel=%0d expected 12 10 0", PCAtual, {Esperando, Parado}, NivelPilha); end
        end
        step(1'b0, 10'd13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (PCAtual !== 10'd13 || Esperando !== 1'b0) begin errors++; $display("FAIL esp_exit: got pc=%0d esp=%b expected 13 0", PCAtual, Esperando); end
        // A ready pulse while running must not be remembered.
        step(1'b0, 10'd14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 10'd20, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 10'd50, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (PCAtual !== 10'd14 || Esperando !== 1'b1) begin errors++; $display("FAIL esp_nolatch: got pc=%0d esp=%b expected 14 1", PCAtual, Esperando); end
    endtask

    task automatic test_wrap();
        step(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'd1023, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'd100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (PCAtual !== 10'd100) begin errors++; $display("FAIL wrap_call: got %0d expected 100", PCAtual); end
        step(1'b0, 10'd555, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++; if (PCAtual !== 10'd0 || NivelPilha !== 4'd0) begin errors++; $display("FAIL wrap_ret: got %0d/%0d expected 0/0", PCAtual, NivelPilha); end
    endtask

    task automatic test_halt_retorno();
        step(1'b0, 10'd30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 10'd31, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++; if (Parado !== 1'b1 || NivelPilha !== 4'd1 || PCAtual !== 10'd30 || ErroPilha !== 1'b0) begin
            errors++; $display("FAIL halt_ret: got par=%b nivel=%0d pc=%0d err=%b expected 1 1 30 0", Parado, NivelPilha, PCAtual, ErroPilha); end
    endtask

    task automatic test_random();
        logic rst;
        int r;
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            rst = (r < 2) || (m_modo == 2 && r < 25);
            step(rst, W'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
            checks++; if (PCAtual !== m_pc) begin errors++; $display("FAIL rnd_pc cycle %0d: got %0d expected %0d", i, PCAtual, m_pc); end
            checks++; if (NivelPilha !== 4'(m_pilha.size())) begin errors++; $display("FAIL rnd_nivel cycle %0d: got %0d expected %0d", i, NivelPilha, m_pilha.size()); end
            checks++; if (ErroPilha !== m_erro) begin errors++; $display("FAIL rnd_erro cycle %0d: got %b expected %b", i, ErroPilha, m_erro); end
            checks++; if (Parado !== (m_modo == 2)) begin errors++; $display("FAIL rnd_parado cycle %0d: got %b expected %b", i, Parado, m_modo == 2); end
            checks++; if (Esperando !== (m_modo == 1)) begin errors++; $display("FAIL rnd_esperando cycle %0d: got %b expected %b", i, Esperando, m_modo == 1); end
        end
    endtask

    initial begin
        reset = 1'b1; NovoEndereco = '0; Chamada = 1'b0; Retorno = 1'b0;
        Halt = 1'b0; EsperaEntrada = 1'b0; EntradaPronta = 1'b0;
        m_pc = '0; m_erro = 1'b0; m_modo = 0;
        test_reset();
        test_sequencial();
        test_chamada_retorno();
        test_overflow();
        test_underflow();
        test_espera();
        test_wrap();
        test_halt_retorno();
        step(1'b1, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
